// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue slice.
//   - ALU function codes, also used by the decoder and the ALU itself.
//   - Operand bus packing order: slot index of A and B on the {B,A} bus.
//   - Hi/lo counter width.
package alu_issue_stage_pkg;

    localparam logic [5:0] ALU_SLL   = 6'h00;
    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_ADD   = 6'h20;

    // Operand slots on out_data: slot k occupies [k*W +: W].
    localparam int OPND_A_SLOT = 0;
    localparam int OPND_B_SLOT = 1;

    localparam int HILO_CNT_W = 4;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and ALU-side signal bundle of the issue stage.
//   slave  : the issue stage (consumes in_*, f1_*, f2_*, hold, flush;
//            drives in_ready and out_*).
//   master : the surrounding pipeline / testbench.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int CTRL_WIDTH    = 6,
    parameter int SHAMT_WIDTH   = 5,
    parameter int REG_IDX_WIDTH = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [REG_IDX_WIDTH-1:0]   in_a_idx;
    logic [DATA_WIDTH-1:0]      in_a_data;
    logic [REG_IDX_WIDTH-1:0]   in_b_idx;
    logic [DATA_WIDTH-1:0]      in_b_data;
    logic [DATA_WIDTH-1:0]      in_imm;
    logic                       in_use_imm;
    logic [CTRL_WIDTH-1:0]      in_ctrl;
    logic [SHAMT_WIDTH-1:0]     in_shamt;
    logic [REG_IDX_WIDTH-1:0]   in_rd;
    logic                       in_wr_en;

    logic                       f1_valid;
    logic [REG_IDX_WIDTH-1:0]   f1_idx;
    logic [DATA_WIDTH-1:0]      f1_data;
    logic                       f1_rdy;
    logic                       f2_valid;
    logic [REG_IDX_WIDTH-1:0]   f2_idx;
    logic [DATA_WIDTH-1:0]      f2_data;

    logic                       hold;
    logic                       flush;

    logic                       out_valid;
    logic [2*DATA_WIDTH-1:0]    out_data;
    logic [CTRL_WIDTH-1:0]      out_ctrl;
    logic [SHAMT_WIDTH-1:0]     out_shamt;
    logic [REG_IDX_WIDTH-1:0]   out_rd;
    logic                       out_wr_en;

    modport slave (
        input  in_valid, in_a_idx, in_a_data, in_b_idx, in_b_data, in_imm,
               in_use_imm, in_ctrl, in_shamt, in_rd, in_wr_en,
               f1_valid, f1_idx, f1_data, f1_rdy, f2_valid, f2_idx, f2_data,
               hold, flush,
        output in_ready, out_valid, out_data, out_ctrl, out_shamt, out_rd,
               out_wr_en
    );

    modport master (
        output in_valid, in_a_idx, in_a_data, in_b_idx, in_b_data, in_imm,
               in_use_imm, in_ctrl, in_shamt, in_rd, in_wr_en,
               f1_valid, f1_idx, f1_data, f1_rdy, f2_valid, f2_idx, f2_data,
               hold, flush,
        input  in_ready, out_valid, out_data, out_ctrl, out_shamt, out_rd,
               out_wr_en
    );

endinterface

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// Combinational operand resolve for one source register.
//   idx, rf_data        : register index and regfile value
//   f1_valid/idx/data   : nearest older writer (wins over f2)
//   f2_valid/idx/data   : second older writer
//   data                : resolved operand; register 0 always reads 0
module operand_fwd_mux #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic [REG_IDX_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    input  logic                     f1_valid,
    input  logic [REG_IDX_WIDTH-1:0] f1_idx,
    input  logic [DATA_WIDTH-1:0]    f1_data,
    input  logic                     f2_valid,
    input  logic [REG_IDX_WIDTH-1:0] f2_idx,
    input  logic [DATA_WIDTH-1:0]    f2_data,
    output logic [DATA_WIDTH-1:0]    data
);

    always_comb begin
        data = rf_data;
        if (idx == '0)
            data = '0;
        else if (f1_valid && f1_idx == idx)
            data = f1_data;
        else if (f2_valid && f2_idx == idx)
            data = f2_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: resolves A/B operands (forwarding and
// immediate select), detects load-use and hi/lo hazards, and registers the
// {B,A} operand bus with ctrl/shamt/rd for the ALU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of alu_issue_stage_if (decode handshake,
//              forwarding inputs, hold/flush, registered ALU outputs)
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CTRL_WIDTH    = 6,
    parameter int SHAMT_WIDTH   = 5,
    parameter int REG_IDX_WIDTH = 5,
    parameter int MULT_LAT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);

    logic [DATA_WIDTH-1:0]    a_p0;
    logic [DATA_WIDTH-1:0]    b_fwd_p0;
    logic [DATA_WIDTH-1:0]    b_p0;
    logic                     data_haz;
    logic                     hilo_haz;
    logic                     is_mult;
    logic                     is_mfhilo;
    logic                     xfer;
    logic [HILO_CNT_W-1:0]    hilo_cnt;

    logic                     vld_p1;
    logic                     wr_en_p1;
    logic [2*DATA_WIDTH-1:0]  opnd_p1;
    logic [CTRL_WIDTH-1:0]    ctrl_p1;
    logic [SHAMT_WIDTH-1:0]   shamt_p1;
    logic [REG_IDX_WIDTH-1:0] rd_p1;

    // ---- stage p0: operand resolve and hazard detection (combinational)
    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_a (
        .idx      (bus.in_a_idx),
        .rf_data  (bus.in_a_data),
        .f1_valid (bus.f1_valid),
        .f1_idx   (bus.f1_idx),
        .f1_data  (bus.f1_data),
        .f2_valid (bus.f2_valid),
        .f2_idx   (bus.f2_idx),
        .f2_data  (bus.f2_data),
        .data     (a_p0)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_b (
        .idx      (bus.in_b_idx),
        .rf_data  (bus.in_b_data),
        .f1_valid (bus.f1_valid),
        .f1_idx   (bus.f1_idx),
        .f1_data  (bus.f1_data),
        .f2_valid (bus.f2_valid),
        .f2_idx   (bus.f2_idx),
        .f2_data  (bus.f2_data),
        .data     (b_fwd_p0)
    );

    assign b_p0 = bus.in_use_imm ? bus.in_imm : b_fwd_p0;

    // A pending load in f1 blocks any consumer of its register; B only counts
    // when it is actually read from the register file.
    assign data_haz = bus.in_valid && bus.f1_valid && !bus.f1_rdy &&
                      (bus.f1_idx != '0) &&
                      ((bus.f1_idx == bus.in_a_idx) ||
                       (!bus.in_use_imm && bus.f1_idx == bus.in_b_idx));

    assign is_mfhilo = (bus.in_ctrl == CTRL_WIDTH'(ALU_MFHI)) ||
                       (bus.in_ctrl == CTRL_WIDTH'(ALU_MFLO));
    assign is_mult   = (bus.in_ctrl == CTRL_WIDTH'(ALU_MULT)) ||
                       (bus.in_ctrl == CTRL_WIDTH'(ALU_MULTU));

    assign hilo_haz = bus.in_valid && (hilo_cnt != '0) && is_mfhilo;

    // Flush always drains the input so decode never deadlocks against a kill.
    assign bus.in_ready = !rst && (bus.flush || (!bus.hold && !data_haz && !hilo_haz));
    assign xfer         = bus.in_valid && bus.in_ready;

    // Counter runs down independent of hold/flush; only a mult that really
    // issues (not flushed) arms it.
    always_ff @(posedge clk) begin
        if (rst)
            hilo_cnt <= '0;
        else if (xfer && !bus.flush && is_mult)
            hilo_cnt <= HILO_CNT_W'(MULT_LAT);
        else if (hilo_cnt != '0)
            hilo_cnt <= hilo_cnt - 1'b1;
    end

    // ---- stage p1: registered ALU inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wr_en_p1 <= 1'b0;
            opnd_p1  <= '0;
            ctrl_p1  <= '0;
            shamt_p1 <= '0;
            rd_p1    <= '0;
        end else if (bus.flush) begin
            vld_p1   <= 1'b0;
            wr_en_p1 <= 1'b0;
        end else if (bus.hold) begin
            vld_p1   <= vld_p1;
            wr_en_p1 <= wr_en_p1;
        end else if (data_haz || hilo_haz) begin
            vld_p1   <= 1'b0;
            wr_en_p1 <= 1'b0;
        end else if (xfer) begin
            vld_p1   <= 1'b1;
            wr_en_p1 <= bus.in_wr_en;
            opnd_p1[OPND_A_SLOT*DATA_WIDTH +: DATA_WIDTH] <= a_p0;
            opnd_p1[OPND_B_SLOT*DATA_WIDTH +: DATA_WIDTH] <= b_p0;
            ctrl_p1  <= bus.in_ctrl;
            shamt_p1 <= bus.in_shamt;
            rd_p1    <= bus.in_rd;
        end else begin
            vld_p1   <= 1'b0;
            wr_en_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_wr_en = wr_en_p1;
    assign bus.out_data  = opnd_p1;
    assign bus.out_ctrl  = ctrl_p1;
    assign bus.out_shamt = shamt_p1;
    assign bus.out_rd    = rd_p1;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the ALU.
- Takes decoded instructions with register-file operands and forwards newer results from two downstream stages. Selects the immediate for operand B.
- Detects data and hi/lo hazards, inserts bubbles, and presents a registered {B,A} operand bus plus ctrl/shamt to the ALU.
- Valid/ready toward decode; hold and flush from pipeline control.

Parameters:
- DATA_WIDTH, 32, operand width
- CTRL_WIDTH, 6, ALU function code width
- SHAMT_WIDTH, 5, shift amount width
- REG_IDX_WIDTH, 5, register index width
- MULT_LAT, 2, cycles after a mult issue before mfhi/mflo may issue (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_a_idx  in  REG_IDX_WIDTH  source A register index
- in_a_data  in  DATA_WIDTH  regfile value of A
- in_b_idx  in  REG_IDX_WIDTH  source B register index
- in_b_data  in  DATA_WIDTH  regfile value of B
- in_imm  in  DATA_WIDTH  extended immediate
- in_use_imm  in  1  B = in_imm, B register unused
- in_ctrl  in  CTRL_WIDTH  ALU function code
- in_shamt  in  SHAMT_WIDTH  shift amount
- in_rd  in  REG_IDX_WIDTH  destination index
- in_wr_en  in  1  writes rd
- f1_valid, f1_idx, f1_data, f1_rdy  in  1/REG_IDX_WIDTH/DATA_WIDTH/1  nearest older writer; f1_rdy=0 means data not yet available (load)
- f2_valid, f2_idx, f2_data  in  1/REG_IDX_WIDTH/DATA_WIDTH  second older writer; always ready
- hold  in  1  downstream stall
- flush  in  1  kill the instruction being issued
- out_valid  out  1  ALU inputs are valid
- out_data  out  2*DATA_WIDTH  operands; A in [DATA_WIDTH-1:0], B in [2*DATA_WIDTH-1:DATA_WIDTH]
- out_ctrl  out  CTRL_WIDTH  ALU function code
- out_shamt  out  SHAMT_WIDTH  shift amount
- out_rd  out  REG_IDX_WIDTH  destination index
- out_wr_en  out  1  writes rd; forced 0 whenever out_valid=0

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ctrl=0, out_shamt=0, out_rd=0, out_wr_en=0, hilo_cnt=0. in_ready is combinational and is 0 while rst=1. Reset mid-stall drops the pending instruction.
- Operand resolve, A (combinational):
  - idx 0 always gives 0.
  - Else if f1_valid && f1_idx==idx, use f1_data.
  - Else if f2_valid && f2_idx==idx, use f2_data.
  - Else use the regfile data.
- Operand resolve, B: same rule as A; if in_use_imm, B=in_imm and the B index is ignored for forwarding and hazards.
- data_haz = in_valid && f1_valid && !f1_rdy && f1_idx!=0 && (f1_idx==in_a_idx || (!in_use_imm && f1_idx==in_b_idx)).
- hilo_haz = in_valid && hilo_cnt!=0 && in_ctrl in {6'h10, 6'h12}.
- Handshake:
  - in_ready = !rst && (flush || (!hold && !data_haz && !hilo_haz)).
  - Transfer occurs when in_valid && in_ready.
- Register update, highest priority first:
  1. flush: out_valid<=0, out_wr_en<=0; the input is consumed and discarded.
  2. hold: all out_* registers keep their values.
  3. data_haz or hilo_haz: bubble; out_valid<=0, out_wr_en<=0, other outputs don't-care.
  4. Transfer: load the resolved operands, ctrl, shamt, rd; out_valid<=1; out_wr_en<=in_wr_en.
  5. Otherwise (!in_valid): out_valid<=0, out_wr_en<=0.
- Latency: 1 cycle from transfer to out_valid.
- Hi/lo counter hilo_cnt, 4 bits:
  - Loads MULT_LAT on a transfer with in_ctrl in {6'h18, 6'h19}.
  - Otherwise decrements when nonzero, every cycle regardless of hold or flush.
  - A flushed mult does not load the counter.
  - A mult issued while the counter is nonzero reloads MULT_LAT.
  - mthi/mtlo (6'h11, 6'h13) never stall.
- Simultaneous events:
  - f1 and f2 hitting the same index: f1 wins.
  - A and B naming the same register: both resolve identically.
  - A hazard while hold=1: hold governs (registers frozen), and in_ready=0 either way.

Decomposition:
- Shared package holds the ALU function-code constants (SLL=6'h00, MFHI=6'h10, MTHI=6'h11, MFLO=6'h12, MTLO=6'h13, MULT=6'h18, MULTU=6'h19, ADD=6'h20, ...) and the operand-bus packing order. These are shared with the ALU and the decoder.
- One sub-module: operand_fwd_mux. It is purely combinational, instantiated twice (A, B), and takes idx, regfile data, and the f1/f2 inputs.
- Hazard logic, hilo counter and pipeline register stay in the top level.

Test Plan:
- Plain issue: a_idx=3 data=5, b_idx=4 data=7, ctrl=6'h20, no forwarding. Next cycle out_valid=1, out_data={32'd7, 32'd5}, out_ctrl=6'h20.
- Forward priority: a_idx=8, f1 (idx 8, data 0xAAAA0000, rdy=1), f2 (idx 8, data 0x1111) → A=0xAAAA0000. Remove f1 → A=0x1111. a_idx=0 with f1 idx 0 → A=0.
- Load-use: f1 (idx 9, rdy=0), in a_idx=9 → in_ready=0 and a bubble (out_valid=0). Next cycle f1_rdy=1 with data 0x42 → transfer, A=0x42. With in_use_imm=1, b_idx=9 and imm=0x10 → no stall, B=0x10.
- Hi/lo: MULT_LAT=2. Issue ctrl 6'h18, then mflo (6'h12) on the next cycle → mflo stalls exactly 2 cycles and issues on the 3rd; mtlo on the next cycle → no stall.
- Hold/flush: hold=1 for 3 cycles → out_* constant, in_ready=0. flush=1 with hold=1 → in_ready=1, next out_valid=0. Flushed 6'h18 → hilo_cnt stays 0.
- Reset mid-stall: during the hilo stall, rst=1 → all outputs 0, counter 0. After release, the pending mflo issues in 1 cycle.
